// File: rtl/mem_access_ctrl.sv
// Memory-stage SRAM access controller: latches the EXE/MEM RAM request, runs the
// multi-cycle asynchronous SRAM handshake and stalls the pipeline until it completes.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  input  logic              mem_req_en,
  input  logic              mem_req_op,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_stall,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rdata_valid,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              op_q;
  logic              op_d;
  logic [DATA_W-1:0] wdata_q;
  logic              drive_q;
  logic              drive_d;
  logic              latch;
  logic              capture;
  logic              ce_n_d;
  logic              oe_n_d;
  logic              we_n_d;

  // Next state, then SRAM strobes decoded from the state being entered (op: 1 = write)
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    latch   = 1'b0;
    capture = 1'b0;
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    drive_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_req_en) begin
          state_d = SETUP;
          op_d    = mem_req_op;
          latch   = 1'b1;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = CNT_LOAD;
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          capture = ~op_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      SETUP: begin
        ce_n_d  = 1'b0;
        oe_n_d  = op_d;
        drive_d = op_d;
      end
      ACCESS: begin
        ce_n_d  = 1'b0;
        oe_n_d  = op_d;
        we_n_d  = ~op_d;
        drive_d = op_d;
      end
      DONE: drive_d = op_d;  // keep write data on the bus for SRAM hold time
      default: ;
    endcase
  end

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      op_q            <= 1'b0;
      wdata_q         <= '0;
      drive_q         <= 1'b0;
      ram_addr        <= '0;
      ram_ce_n        <= 1'b1;
      ram_oe_n        <= 1'b1;
      ram_we_n        <= 1'b1;
      mem_rdata       <= '0;
      mem_rdata_valid <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      op_q            <= op_d;
      drive_q         <= drive_d;
      ram_ce_n        <= ce_n_d;
      ram_oe_n        <= oe_n_d;
      ram_we_n        <= we_n_d;
      mem_rdata_valid <= capture;
      if (latch) begin
        ram_addr <= ADDR_W'(mem_addr);
        wdata_q  <= mem_wdata;
      end
      if (capture) begin
        mem_rdata <= ram_data;
      end
    end
  end

  assign ram_data = drive_q ? wdata_q : {DATA_W{1'bz}};

  // Stall starts in the request cycle itself so upstream freezes before the handshake
  assign mem_stall = rst && ((state_q == IDLE && mem_req_en) ||
                             state_q == SETUP || state_q == ACCESS);

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access controller for the 16-bit pipelined CPU. It takes the RAM request held in the EXE/MEM pipeline register (enable, read/write, address, write data). It runs the multi-cycle handshake with the external asynchronous SRAM and stalls the pipeline until the access completes. For reads it returns the data to the MEM/WB path.

## Interface
Parameters:
- ADDR_W, 18, SRAM address width; CPU address zero-extended to this width
- DATA_W, 16, data width (pipeline word and SRAM word)
- WAIT_CYCLES, 1, cycles spent in ACCESS (legal range 1..15)

Ports:
- clk_50MHz  in  1  system clock, all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- mem_req_en  in  1  RAM access requested (from em_RAM_en)
- mem_req_op  in  1  0 = read, 1 = write (from em_RAM_op)
- mem_addr  in  DATA_W  word address (from em_ALU_data)
- mem_wdata  in  DATA_W  store data (from em_RAM_WB_data)
- mem_stall  out  1  freeze PC, IF/ID, ID/EXE and EXE/MEM registers
- mem_rdata  out  DATA_W  last captured read word
- mem_rdata_valid  out  1  mem_rdata belongs to the current request (DONE of a read)
- ram_addr  out  ADDR_W  SRAM address
- ram_data  inout  DATA_W  SRAM data bus, driven only during writes
- ram_ce_n  out  1  SRAM chip enable, active-low
- ram_oe_n  out  1  SRAM output enable, active-low
- ram_we_n  out  1  SRAM write enable, active-low

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE. A 4-bit wait counter is used in ACCESS.
- IDLE: if mem_req_en=1, latch the request and go to SETUP. Otherwise stay in IDLE.
  - Latched items: op, address (zero-extended), write data.
- SETUP: go to ACCESS and load the counter with WAIT_CYCLES-1.
- ACCESS: when the counter is 0, go to DONE. Otherwise decrement the counter.
  - On a read, ram_data is captured into mem_rdata at the ACCESS -> DONE edge.
- DONE: unconditionally go to IDLE.
- SRAM outputs are registered and take the value of the state being entered. They are glitch-free.

| State | ram_ce_n | ram_oe_n | ram_we_n | ram_data |
|---|---|---|---|---|
| IDLE | 1 | 1 | 1 | Z |
| SETUP / ACCESS (read) | 0 | 0 | 1 | Z |
| SETUP (write) | 0 | 1 | 1 | driven with wdata |
| ACCESS (write) | 0 | 1 | 0 | driven with wdata |
| DONE (read) | 1 | 1 | 1 | Z |
| DONE (write) | 1 | 1 | 1 | still driven (hold time) |

- ram_addr is held from SETUP through DONE, and keeps its last value in IDLE.
- mem_stall is combinational: (IDLE & mem_req_en) | SETUP | ACCESS. It is 0 in DONE, so the pipeline advances at the DONE edge.
- Upstream guarantees that mem_req_* stay stable while mem_stall=1. The block still uses its latched copies from IDLE onward.
- mem_rdata holds its value until the next read capture. Writes never change it.
- mem_rdata_valid is 1 only in DONE of a read.
- Back-to-back requests: the next request is seen in IDLE on the cycle after DONE. No request is ever serviced twice.

## Timing
- Reset values:
  - state = IDLE, counter = 0
  - ram_ce_n = ram_oe_n = ram_we_n = 1
  - ram_data released (Z), ram_addr = 0
  - mem_rdata = 0, mem_rdata_valid = 0
  - mem_stall = 0 while rst = 0, regardless of mem_req_en
- Access latency is 3 + WAIT_CYCLES cycles from the IDLE cycle with the request to the end of DONE. mem_stall is high for 2 + WAIT_CYCLES cycles.
  - Default (WAIT_CYCLES=1): 4 cycles, 3 stall cycles.
- ram_we_n is low for exactly WAIT_CYCLES cycles. Address and data are stable one cycle before the falling edge of ram_we_n and one cycle after its rising edge.
- Read data is sampled after oe_n has been low for 1 + WAIT_CYCLES cycles, which is 40 ns at the defaults.
- Reset asserted mid-access:
  - Immediately (asynchronously): ram_we_n/ram_oe_n/ram_ce_n go to 1 and the bus is released.
  - The access is aborted and not retried. A write in progress may leave that SRAM word undefined.
- mem_req_en=0 in IDLE: no SRAM activity and ram_ce_n stays 1.

## Test plan
- **Reset:** assert rst=0 during ACCESS of a write -> same cycle ram_we_n=1, ram_ce_n=1, ram_data=Z, mem_stall=0. After release, state is IDLE and mem_rdata=0.
- **Single write:** write 0x1234 to addr 0x0040 with WAIT_CYCLES=1 ->
  - mem_stall high for 3 cycles.
  - ram_we_n low for exactly 1 cycle, with ram_addr=0x00040 and ram_data=0x1234 stable one cycle before and after.
  - mem_rdata_valid stays 0.
- **Single read:** read addr 0x0040 with the SRAM model holding 0x1234 -> mem_rdata=0x1234 with mem_rdata_valid=1 in DONE, mem_stall low in that same cycle, and ram_oe_n low for 2 cycles.
- **Back-to-back:** write 0xBEEF to 0x0100, then read 0x0100 on the cycle after DONE ->
  - Two separate 4-cycle accesses, with IDLE (stall=1) between them.
  - The read returns 0xBEEF.
  - Exactly one we_n pulse in total.
- **Wait states:** with WAIT_CYCLES=3, read addr 0xFFFF -> ram_addr=0x0FFFF (zero-extended), mem_stall high for 5 cycles, ram_oe_n low for 4 cycles.
- **Idle / persistence:** mem_req_en=0 for 10 cycles after a read returned 0x5A5A -> ce_n/oe_n/we_n all stay 1, ram_data=Z, mem_rdata stays 0x5A5A, mem_rdata_valid=0.
